// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, keymap table and row priority encoder for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam logic [3:0] KEYMAP [ROWS][COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };
  function automatic logic [2:0] row_priority(input logic [ROWS-1:0] rs);
    row_priority = {~&rs, 2'd0};
    for (int i = ROWS - 1; i >= 0; i--)
      if (!rs[i]) row_priority[1:0] = 2'(i);
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running column dwell counter, pulses on the last dwell cycle
module scan_tick_gen #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic clock,
  input  logic reset_n,
  output logic sample_tick
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] cnt;
  assign sample_tick = cnt == W'(SCAN_DIV - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= sample_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan with per-key debounce, one event per press, hex entry register
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_COUNT = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] sixteen_bit_number
);
  localparam int DW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_COUNT);
  logic [3:0] row_m, row_s;
  logic tick, hit;
  logic [1:0] idx, col_idx, cand_row, cand_col;
  logic [DW-1:0] deb_cnt, rel_cnt;
  state_t state;
  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clock(clock),
    .reset_n(reset_n),
    .sample_tick(tick)
  );
  assign {hit, idx} = row_priority(row_s);
  assign col = ~(4'b0001 << col_idx);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
      state <= SCAN;
      col_idx <= '0;
      cand_row <= '0;
      cand_col <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
      key_valid <= 1'b0;
      key_code <= '0;
      sixteen_bit_number <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      key_valid <= 1'b0;
      if (clear) sixteen_bit_number <= '0;
      else if (key_valid) sixteen_bit_number <= {sixteen_bit_number[11:0], key_code};
      case (state)
        SCAN:
          if (tick) begin
            if (hit) begin
              cand_row <= idx;
              cand_col <= col_idx;
              deb_cnt <= DW'(1);
              state <= DEBOUNCE;
            end else col_idx <= col_idx + 1'b1;
          end
        DEBOUNCE:
          if (deb_cnt == DMAX) begin
            key_valid <= 1'b1;
            key_code <= KEYMAP[cand_row][cand_col];
            rel_cnt <= '0;
            state <= HELD;
          end else if (tick) begin
            if (hit && idx == cand_row) deb_cnt <= deb_cnt + 1'b1;
            else begin
              state <= SCAN;
              col_idx <= col_idx + 1'b1;
            end
          end
        HELD:
          // release needs DEBOUNCE_COUNT consecutive all-high samples; any low restarts it
          if (tick) begin
            if (row_s != 4'hF) rel_cnt <= '0;
            else if (rel_cnt == DMAX - 1'b1) begin
              rel_cnt <= '0;
              state <= SCAN;
              col_idx <= col_idx + 1'b1;
            end else rel_cnt <= rel_cnt + 1'b1;
          end
        default: state <= SCAN;
      endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random key presses against a keypad matrix model and entry model
module tb_keypad_scanner;
  localparam int SD = 8;
  localparam int DC = 3;
  logic clock = 1'b0;
  logic reset_n;
  logic [3:0] row, col, key_code;
  logic clear, key_valid;
  logic [15:0] sixteen_bit_number;
  logic [15:0] pk;
  logic [15:0] exp_num;
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  int chk = 0, errs = 0, pulses = 0, exp_pulses = 0, pe = 0, n;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_COUNT(DC)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .row(row),
    .col(col),
    .clear(clear),
    .key_valid(key_valid),
    .key_code(key_code),
    .sixteen_bit_number(sixteen_bit_number)
  );

  always #5 clock = ~clock;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(pk[r*4 +: 4] & ~col);
  end

  always @(posedge clock) if (key_valid === 1'b1) pulses <= pulses + 1;
  always @(posedge clock or negedge reset_n) pe <= reset_n ? pe + 1 : 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    chk++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (key_valid !== 1'b1 && cnt < 40 * SD);
    check("valid_seen", {15'd0, key_valid}, 16'd1);
  endtask

  task automatic align(input int c);
    int k = 0;
    logic [3:0] want;
    want = ~(4'b0001 << c);
    do begin
      @(negedge clock);
      k++;
    end while (!(pe % SD == SD / 2 && col == want) && k < 10 * SD);
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_col"}, {12'd0, col}, 16'h000E);
    check({tag, "_kv"}, {15'd0, key_valid}, 16'd0);
    check({tag, "_code"}, {12'd0, key_code}, 16'd0);
    check({tag, "_num"}, sixteen_bit_number, 16'd0);
  endtask

  task automatic press_key(input int r, input int c, input int hold);
    int w;
    pk[r*4 + c] = 1'b1;
    wait_valid(w);
    check("code", {12'd0, key_code}, {12'd0, kmap[r*4 + c]});
    exp_num = (exp_num << 4) | {12'd0, kmap[r*4 + c]};
    exp_pulses++;
    @(negedge clock);
    check("number", sixteen_bit_number, exp_num);
    cycles(hold * SD);
    pk = '0;
    cycles((DC + 2) * SD);
    check("pulses", 16'(pulses), 16'(exp_pulses));
  endtask

  initial begin
    reset_n = 1'b0;
    pk = '0;
    clear = 1'b0;
    exp_num = '0;
    cycles(3);
    reset_vals("rst");
    reset_n = 1'b1;
    // 1: clean press of "6", latency, single pulse, release back to the ring
    align(2);
    pk[6] = 1'b1;
    wait_valid(n);
    check("latency", 16'(n), 16'(SD / 2 + (DC - 1) * SD + 1));
    check("code6", {12'd0, key_code}, 16'h0006);
    exp_pulses++;
    exp_num = 16'h0006;
    @(negedge clock);
    check("kv_one_cycle", {15'd0, key_valid}, 16'd0);
    check("num6", sixteen_bit_number, 16'h0006);
    cycles(10 * SD);
    check("held_pulses", 16'(pulses), 16'(exp_pulses));
    check("held_col", {12'd0, col}, 16'h000B);
    pk = '0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (col == 4'b1011 && n < 10 * SD);
    check("release_lat", 16'(n >= 2 * SD + 1 && n <= 3 * SD + 3), 16'd1);
    check("release_col", {12'd0, col}, 16'h0007);
    // 2: entry register shift and top-nibble wrap
    press_key(0, 0, 1);
    press_key(0, 1, 0);
    press_key(0, 2, 2);
    press_key(0, 3, 0);
    check("num_123A", sixteen_bit_number, 16'h123A);
    press_key(1, 1, 1);
    check("num_23A5", sixteen_bit_number, 16'h23A5);
    // 3: bounce on "*" must not produce an event until stable
    align(0);
    pk[12] = 1'b1;
    cycles(2 * SD);
    pk = '0;
    cycles(SD);
    check("bounce_pulses", 16'(pulses), 16'(exp_pulses));
    check("bounce_col", {12'd0, col}, 16'h000D);
    pk[12] = 1'b1;
    wait_valid(n);
    check("bounce_wait", 16'(n >= 2 * SD), 16'd1);
    check("codeE", {12'd0, key_code}, 16'h000E);
    exp_pulses++;
    exp_num = (exp_num << 4) | 16'hE;
    pk = '0;
    cycles((DC + 2) * SD);
    check("bounce_once", 16'(pulses), 16'(exp_pulses));
    // 4: two keys in one column, lowest row wins, the other is ignored while held
    pk[9] = 1'b1;
    pk[1] = 1'b1;
    wait_valid(n);
    check("code2", {12'd0, key_code}, 16'h0002);
    exp_pulses++;
    exp_num = (exp_num << 4) | 16'h2;
    pk[1] = 1'b0;
    cycles(10 * SD);
    check("multi_col", {12'd0, col}, 16'h000D);
    check("multi_pulses", 16'(pulses), 16'(exp_pulses));
    pk = '0;
    cycles((DC + 2) * SD);
    check("multi_after", 16'(pulses), 16'(exp_pulses));
    check("multi_num", sixteen_bit_number, exp_num);
    // 5: clear on the key_valid cycle wins over the shift
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    exp_num = '0;
    check("clear", sixteen_bit_number, 16'h0000);
    press_key(0, 0, 0);
    press_key(0, 1, 0);
    check("num_12", sixteen_bit_number, 16'h0012);
    pk[10] = 1'b1;
    wait_valid(n);
    clear = 1'b1;
    check("clr_kv", {15'd0, key_valid}, 16'd1);
    check("code9", {12'd0, key_code}, 16'h0009);
    exp_pulses++;
    @(negedge clock);
    clear = 1'b0;
    check("clr_num", sixteen_bit_number, 16'h0000);
    pk = '0;
    cycles((DC + 2) * SD);
    // 6: reset mid-debounce and mid-held, held key re-detected afterwards
    align(0);
    pk[0] = 1'b1;
    cycles(SD);
    reset_n = 1'b0;
    #1;
    reset_vals("rst_deb");
    cycles(3);
    check("rst_deb_pulses", 16'(pulses), 16'(exp_pulses));
    reset_n = 1'b1;
    exp_num = '0;
    wait_valid(n);
    check("redetect1", {12'd0, key_code}, 16'h0001);
    exp_pulses++;
    @(negedge clock);
    check("redetect_num", sixteen_bit_number, 16'h0001);
    cycles(3 * SD);
    reset_n = 1'b0;
    #1;
    reset_vals("rst_held");
    cycles(3);
    reset_n = 1'b1;
    wait_valid(n);
    check("redetect2", {12'd0, key_code}, 16'h0001);
    exp_pulses++;
    exp_num = 16'h0001;
    pk = '0;
    cycles((DC + 2) * SD);
    check("rst_pulses", 16'(pulses), 16'(exp_pulses));
    // random presses against the entry model
    for (int i = 0; i < 10; i++)
      press_key(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(4)));
    $display("Result: errors=%0d of %0d checks", errs, chk);
    $finish;
  end
endmodule
